// File: rtl/amp_ctrl_pkg.sv
// Shared definitions for the amplifier enable controller: channel state codes
// and the fault-event counter width.
package amp_ctrl_pkg;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int FEV_W = 8;

endpackage

// File: rtl/amp_chan_fsm.sv
// One channel's enable sequencer: OFF -> ARM (settling delay) -> ON, with a
// latched FAULT that only an explicit host clear can release.
module amp_chan_fsm
  import amp_ctrl_pkg::*;
#(
  parameter int unsigned ENABLE_DLY = 16'd4800,
  parameter int          DLY_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       safety_fault,
  input  logic       estop_n,
  input  logic       wr,
  input  logic       wr_en,
  input  logic       clr,
  output logic [1:0] state,
  output logic       enter_fault
);

  // A zero delay still spends one cycle in ARM.
  localparam logic [DLY_W-1:0] LOAD_VAL =
    (ENABLE_DLY == 0) ? '0 : DLY_W'(ENABLE_DLY - 1);

  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] cnt_nx;
  logic [1:0]       state_nx;
  logic             arm_or_on;

  assign arm_or_on   = (state == ST_ARM) || (state == ST_ON);
  assign enter_fault = reset && arm_or_on && safety_fault;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (arm_or_on && safety_fault) begin
      state_nx = ST_FAULT;
    end else if (!estop_n) begin
      if (arm_or_on) state_nx = ST_OFF;
    end else if (clr && (state == ST_FAULT)) begin
      if (!safety_fault) state_nx = ST_OFF;
    end else if (wr && wr_en && (state == ST_OFF)) begin
      state_nx = ST_ARM;
      cnt_nx   = LOAD_VAL;
    end else if (wr && !wr_en && arm_or_on) begin
      state_nx = ST_OFF;
    end else if (state == ST_ARM) begin
      if (cnt == '0) state_nx = ST_ON;
      else           cnt_nx   = cnt - DLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: rtl/amp_enable_ctrl.sv
// Drives the QLA amplifier enables from per-channel sequencers, with a global
// e-stop override and a saturating count of fault entries for the host.
module amp_enable_ctrl
  import amp_ctrl_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int unsigned ENABLE_DLY = 16'd4800,
  parameter int          DLY_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   safety_fault,
  input  logic                estop_n,
  input  logic                host_wr,
  input  logic [NUM_CH-1:0]   host_mask,
  input  logic [NUM_CH-1:0]   host_en,
  input  logic                host_clr,
  input  logic [NUM_CH-1:0]   clr_mask,
  output logic [NUM_CH-1:0]   amp_en,
  output logic [NUM_CH-1:0]   fault_latched,
  output logic [2*NUM_CH-1:0] chan_state,
  output logic [FEV_W-1:0]    fault_events
);

  function automatic logic [FEV_W-1:0] sat_add(input logic [FEV_W-1:0] a,
                                               input logic [FEV_W:0]   b);
    logic [FEV_W+1:0] sum;
    sum = {2'b00, a} + {1'b0, b};
    if (sum > (FEV_W+2)'({FEV_W{1'b1}})) return {FEV_W{1'b1}};
    return sum[FEV_W-1:0];
  endfunction

  logic [NUM_CH-1:0][1:0] st;
  logic [NUM_CH-1:0]      enter_fault;
  logic [FEV_W:0]         n_enter;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    amp_chan_fsm #(
      .ENABLE_DLY (ENABLE_DLY),
      .DLY_W      (DLY_W)
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .safety_fault (safety_fault[i]),
      .estop_n      (estop_n),
      .wr           (host_wr && host_mask[i]),
      .wr_en        (host_en[i]),
      .clr          (host_clr && clr_mask[i]),
      .state        (st[i]),
      .enter_fault  (enter_fault[i])
    );

    // Outputs decode straight from the state flops, no input-to-output path.
    assign amp_en[i]           = (st[i] == ST_ON);
    assign fault_latched[i]    = (st[i] == ST_FAULT);
    assign chan_state[2*i +: 2] = st[i];
  end

  always_comb begin
    n_enter = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_enter = n_enter + (FEV_W+1)'(enter_fault[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) fault_events <= '0;
    else        fault_events <= sat_add(fault_events, n_enter);
  end

endmodule

// File: tb/tb_amp_enable_ctrl.sv
// Scoreboard bench for amp_enable_ctrl: a driver pushes model expectations,
// a monitor pops and compares the DUT outputs once per cycle.
module tb_amp_enable_ctrl;

  localparam int NUM_CH = 4;
  localparam int D      = 8;

  localparam int M_OFF = 0, M_ARM = 1, M_ON = 2, M_FAULT = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_CH-1:0]   safety_fault;
  logic                estop_n;
  logic                host_wr;
  logic [NUM_CH-1:0]   host_mask;
  logic [NUM_CH-1:0]   host_en;
  logic                host_clr;
  logic [NUM_CH-1:0]   clr_mask;
  logic [NUM_CH-1:0]   amp_en;
  logic [NUM_CH-1:0]   fault_latched;
  logic [2*NUM_CH-1:0] chan_state;
  logic [7:0]          fault_events;

  amp_enable_ctrl #(
    .NUM_CH     (NUM_CH),
    .ENABLE_DLY (D),
    .DLY_W      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .safety_fault  (safety_fault),
    .estop_n       (estop_n),
    .host_wr       (host_wr),
    .host_mask     (host_mask),
    .host_en       (host_en),
    .host_clr      (host_clr),
    .clr_mask      (clr_mask),
    .amp_en        (amp_en),
    .fault_latched (fault_latched),
    .chan_state    (chan_state),
    .fault_events  (fault_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0]   amp;
    logic [NUM_CH-1:0]   flt;
    logic [2*NUM_CH-1:0] st;
    logic [7:0]          ev;
    int                  cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  int mode  [NUM_CH];
  int on_at [NUM_CH];
  int events;
  int cyc = 0;

  task automatic chk(input string name, input int at, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, at, act, req);
    end
  endtask

  // Reference rules applied per channel; ARM completion is tracked as the
  // absolute edge number at which the channel turns on.
  task automatic model_edge(input logic r, input logic [NUM_CH-1:0] f,
                            input logic e, input logic w,
                            input logic [NUM_CH-1:0] m,
                            input logic [NUM_CH-1:0] en, input logic c,
                            input logic [NUM_CH-1:0] cm);
    int   nf;
    bit   active;
    bit   done;
    exp_t x;
    nf = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      active = (mode[i] == M_ARM) || (mode[i] == M_ON);
      done   = 0;
      if (!r) begin
        mode[i] = M_OFF;
      end else if (active && f[i]) begin
        mode[i] = M_FAULT;
        nf++;
      end else if (!e) begin
        if (active) mode[i] = M_OFF;
      end else if (c && cm[i] && mode[i] == M_FAULT) begin
        if (!f[i]) mode[i] = M_OFF;
      end else begin
        if (w && m[i]) begin
          if (mode[i] == M_OFF && en[i]) begin
            mode[i]  = M_ARM;
            on_at[i] = cyc + D;
            done     = 1;
          end else if (active && !en[i]) begin
            mode[i] = M_OFF;
            done    = 1;
          end
        end
        if (!done && mode[i] == M_ARM && cyc == on_at[i]) mode[i] = M_ON;
      end
    end
    if (!r) events = 0;
    else    events = (events + nf > 255) ? 255 : events + nf;

    for (int i = 0; i < NUM_CH; i++) begin
      x.amp[i]        = (mode[i] == M_ON);
      x.flt[i]        = (mode[i] == M_FAULT);
      x.st[2*i +: 2]  = 2'(mode[i]);
    end
    x.ev  = 8'(events);
    x.cyc = cyc;
    q.push_back(x);
  endtask

  task automatic step(input logic r, input logic [NUM_CH-1:0] f, input logic e,
                      input logic w, input logic [NUM_CH-1:0] m,
                      input logic [NUM_CH-1:0] en, input logic c,
                      input logic [NUM_CH-1:0] cm);
    reset        = r;
    safety_fault = f;
    estop_n      = e;
    host_wr      = w;
    host_mask    = m;
    host_en      = en;
    host_clr     = c;
    clr_mask     = cm;
    model_edge(r, f, e, w, m, en, c, cm);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, '0, 1, 0, '0, '0, 0, '0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("amp_en",        mon_e.cyc, 8'(amp_en),        8'(mon_e.amp));
      chk("fault_latched", mon_e.cyc, 8'(fault_latched), 8'(mon_e.flt));
      chk("chan_state",    mon_e.cyc, chan_state,        mon_e.st);
      chk("fault_events",  mon_e.cyc, fault_events,      mon_e.ev);
    end
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode[i]  = M_OFF;
      on_at[i] = 0;
    end
    events = 0;

    // reset, then enable ch0 and let it settle into ON
    step(0, '0, 1, 0, '0, '0, 0, '0);
    step(0, '0, 1, 0, '0, '0, 0, '0);
    step(1, '0, 1, 1, 4'b0001, 4'b0001, 0, '0);
    idle(D + 1);

    // fault while ON, then an enable attempt on the latched channel
    step(1, 4'b0001, 1, 0, '0, '0, 0, '0);
    idle(1);
    step(1, '0, 1, 1, 4'b0001, 4'b0001, 0, '0);

    // clear refused while fault persists, accepted once it drops
    step(1, 4'b0001, 1, 0, '0, '0, 1, 4'b0001);
    step(1, '0, 1, 0, '0, '0, 1, 4'b0001);

    // clear and enable in the same cycle leave ch0 OFF
    step(1, '0, 1, 1, 4'b0001, 4'b0001, 0, '0);
    idle(D + 1);
    step(1, 4'b0001, 1, 0, '0, '0, 0, '0);
    step(1, '0, 1, 1, 4'b0001, 4'b0001, 1, 4'b0001);
    idle(2);

    // e-stop with ch0 ON, ch1 ARM, ch2 FAULT
    step(1, '0, 1, 1, 4'b0101, 4'b0101, 0, '0);
    idle(D + 1);
    step(1, 4'b0100, 1, 0, '0, '0, 0, '0);
    step(1, '0, 1, 1, 4'b0010, 4'b0010, 0, '0);
    idle(2);
    step(1, '0, 0, 0, '0, '0, 0, '0);
    idle(1);

    // fault outranks e-stop
    step(1, '0, 1, 1, 4'b0001, 4'b0001, 0, '0);
    idle(D + 1);
    step(1, 4'b0001, 0, 0, '0, '0, 0, '0);

    // reset in the middle of ARM
    step(1, '0, 1, 0, '0, '0, 1, 4'hF);
    step(1, '0, 1, 1, 4'b0001, 4'b0001, 0, '0);
    idle(2);
    step(0, '0, 1, 0, '0, '0, 0, '0);
    idle(D + 3);

    // multi-channel faults until the counter saturates
    for (int rnd = 0; rnd < 66; rnd++) begin
      step(1, '0, 1, 0, '0, '0, 1, 4'hF);
      step(1, '0, 1, 1, 4'hF, 4'hF, 0, '0);
      idle(D);
      step(1, 4'hF, 1, 0, '0, '0, 0, '0);
    end

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [NUM_CH-1:0] f;
      for (int i = 0; i < NUM_CH; i++) f[i] = ($urandom_range(15) == 0);
      step(($urandom_range(63) != 0), f, ($urandom_range(31) != 0),
           ($urandom_range(3) == 0), 4'($urandom), 4'($urandom),
           ($urandom_range(7) == 0), 4'($urandom));
    end

    idle(2);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drain", cyc, 8'(q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
